wf68k30l_bus_slave: RTL and testbench
=====================================

WF68K30L_BUS_SLAVE -- requirements
Module: wf68k30l_bus_slave

Interface
REQ-001 Parameter BASE, 32'h0000_0000, address match value.
REQ-002 Parameter MASK, 32'h0000_0000, address compare mask; 0 means respond to all non-CPU-space cycles.
REQ-003 Parameter WAIT_STATES, 4, extra cycles inserted between MEM_ACK and DSACKn assertion (0..15).
REQ-004 Parameter TIMEOUT, 255, watchdog limit in cycles from MEM_REQ assertion (1..1023).
REQ-005 CLK  in  1  single clock, shared with the core; all inputs sampled on rising edge.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 ADR_IN  in  32  CPU address; FC_IN  in  3  function code; SIZE  in  2  transfer size; RWn  in  1  1=read.
REQ-008 ASn, DSn  in  1 each  CPU address/data strobes, active-low.
REQ-009 DATA_FROM_CPU  in  32; DATA_TO_CPU  out  32; DATA_EN  out  1  read data valid/drive enable.
REQ-010 DSACKn  out  2  32-bit port termination, active-low; BERRn  out  1  bus error, active-low.
REQ-011 MEM_REQ  out  1; MEM_WE  out  1; MEM_ADDR  out  30 (longword address); MEM_BE  out  4 (bit3 = D31:24); MEM_WDATA  out  32.
REQ-012 MEM_RDATA  in  32; MEM_ACK  in  1  one-cycle completion pulse; MEM_ERR  in  1  qualifies MEM_ACK as failed.

Function
REQ-013 The block SHALL select a cycle when ASn=0, DSn=0, FC_IN!=3'b111 and (ADR_IN & MASK)==BASE.
REQ-014 States SHALL be IDLE, REQ, WAIT, TERM, BERR, DRAIN.
REQ-015 IDLE->REQ on a selected cycle; MEM_REQ SHALL assert the cycle after entry and hold until MEM_ACK.
REQ-016 MEM_ADDR, MEM_WE (=~RWn), MEM_BE, MEM_WDATA SHALL be latched at IDLE->REQ and held stable while MEM_REQ=1.
REQ-017 Byte enables SHALL cover lanes ADR_IN[1:0] through min(3, ADR_IN[1:0]+len-1), len from SIZE: 01=1, 10=2, 11=3, 00=4.
REQ-018 REQ with MEM_ACK=1, MEM_ERR=0 SHALL latch MEM_RDATA and go to WAIT (WAIT_STATES>0) or directly to TERM.
REQ-019 WAIT SHALL count exactly WAIT_STATES cycles, then go to TERM.
REQ-020 TERM SHALL drive DSACKn=2'b00 and, for reads, DATA_EN=1 with latched data, until ASn is sampled high; then IDLE.
REQ-021 REQ with MEM_ACK=1, MEM_ERR=1 SHALL go to BERR; BERR drives BERRn=0, DSACKn=2'b11 until ASn high; then IDLE.
REQ-022 ASn sampled high in REQ or WAIT (aborted cycle) SHALL go to DRAIN: no termination driven, MEM_REQ held until MEM_ACK, then IDLE.
REQ-023 DSACKn, BERRn and DATA_EN SHALL return inactive in the cycle IDLE is re-entered.
REQ-024 A new cycle SHALL NOT be accepted until IDLE is re-entered (ASn negation required between cycles).
REQ-025 MEM_ACK outside REQ/DRAIN SHALL be ignored.

Reset
REQ-026 RESET SHALL force IDLE, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_WDATA=0, DATA_TO_CPU=0, DATA_EN=0, DSACKn=2'b11, BERRn=1, counters 0.
REQ-027 RESET mid-cycle SHALL abandon the cycle without draining the memory side.

Configuration
REQ-028 With WF68K30L_BUS_SLAVE_WATCHDOG_EN defined, a counter SHALL start at MEM_REQ assertion; reaching TIMEOUT in REQ SHALL drop MEM_REQ and go to BERR; reaching TIMEOUT in DRAIN SHALL drop MEM_REQ and go to IDLE.
REQ-029 Without WF68K30L_BUS_SLAVE_WATCHDOG_EN, no watchdog logic SHALL exist and REQ/DRAIN wait indefinitely for MEM_ACK.

Structure
REQ-030 State enum, SIZE encodings and the BE-derivation function SHALL live in the shared wf68k30L package.
REQ-031 One sub-module, wf68k30l_bus_slave_be (combinational SIZE/ADR to MEM_BE), SHALL be instantiated.

Verification
REQ-032 Longword read, ADR 0x100, WAIT_STATES=0, MEM_ACK 2 cycles after MEM_REQ, RDATA 0xDEADBEEF -> MEM_BE=4'b1111, DSACKn=00, DATA_TO_CPU=0xDEADBEEF, DATA_EN=1 until ASn high.
REQ-033 Byte write ADR 0x103 -> MEM_BE=4'b0001, MEM_WE=1; word at 0x101 -> 4'b0110; 3-byte at 0x102 -> 4'b0011.
REQ-034 WAIT_STATES=3: DSACKn asserts exactly 4 cycles after the cycle MEM_ACK is sampled.
REQ-035 MEM_ACK with MEM_ERR=1 -> BERRn=0, DSACKn=11 until ASn negation; FC_IN=3'b111 cycle -> no MEM_REQ, no response.
REQ-036 ASn negated while in REQ -> no DSACKn; MEM_REQ held until MEM_ACK; watchdog build, TIMEOUT=16, no MEM_ACK -> BERRn=0 after 16 cycles.

Source files
------------

// File: rtl/wf68k30l_bus_slave_pkg.sv
// ---------------------------------------------------------------------------
// wf68k30l_bus_slave_pkg
// Shared types and helpers for the WF68K30L asynchronous-bus memory slave:
//   - state_t      : slave FSM states (also exported on the debug port)
//   - SIZE_*       : 68030 SIZE[1:0] encodings
//   - FC_CPU_SPACE : function code of CPU-space cycles (never answered)
//   - size_len()   : transfer length in bytes for a SIZE encoding
//   - calc_be()    : byte-lane enables for a SIZE / ADR[1:0] pair
// ---------------------------------------------------------------------------
package wf68k30l_bus_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_TERM  = 3'd3,
    ST_BERR  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam logic [1:0] SIZE_LONG  = 2'b00;
  localparam logic [1:0] SIZE_BYTE  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_THREE = 2'b11;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

  function automatic int size_len(input logic [1:0] size);
    int len;
    case (size)
      SIZE_BYTE:  len = 1;
      SIZE_WORD:  len = 2;
      SIZE_THREE: len = 3;
      default:    len = 4;
    endcase
    return len;
  endfunction

  // Byte offset k within the longword maps to MEM_BE[3-k] because the bus is
  // big-endian: offset 0 travels on D31:24. The transfer is clipped at the
  // longword boundary; the CPU continues any remainder in a follow-up cycle.
  function automatic logic [3:0] calc_be(input logic [1:0] size,
                                         input logic [1:0] ofs);
    logic [3:0] be;
    int first;
    int last;
    first = int'(ofs);
    last  = first + size_len(size) - 1;
    if (last > 3) last = 3;
    be = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (k >= first && k <= last) be[2'(3 - k)] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/wf68k30l_bus_slave_be.sv
// ---------------------------------------------------------------------------
// wf68k30l_bus_slave_be
// Combinational byte-enable decoder.
// Ports:
//   SIZE    in  2  68030 transfer size
//   ADR_LO  in  2  ADR_IN[1:0], starting byte offset in the longword
//   BE      out 4  byte-lane enables, bit3 = D31:24
// ---------------------------------------------------------------------------
module wf68k30l_bus_slave_be
  import wf68k30l_bus_slave_pkg::*;
(
  input  logic [1:0] SIZE,
  input  logic [1:0] ADR_LO,
  output logic [3:0] BE
);

  always_comb begin
    BE = calc_be(SIZE, ADR_LO);
  end

endmodule

// File: rtl/wf68k30l_bus_slave.sv
// ---------------------------------------------------------------------------
// wf68k30l_bus_slave
// Bridges a 68030 asynchronous bus cycle onto a simple request/acknowledge
// memory port and terminates it as a 32-bit port (DSACKn=00) or with BERRn.
//
// Parameters: BASE/MASK address decode (MASK=0 answers every non-CPU-space
// cycle), WAIT_STATES (0..15) extra cycles between MEM_ACK and DSACKn,
// TIMEOUT (1..1023) watchdog limit in cycles.
//
// Optional feature: define WF68K30L_BUS_SLAVE_WATCHDOG_EN to build a watchdog
// that ends REQ with a bus error and DRAIN silently after TIMEOUT cycles.
//
// Ports:
//   CLK, RESET                 clock, asynchronous active-high reset
//   ADR_IN, FC_IN, SIZE, RWn   CPU address, function code, size, 1=read
//   ASn, DSn                   CPU strobes, active-low
//   DATA_FROM_CPU              write data
//   DATA_TO_CPU, DATA_EN       read data and its drive enable
//   DSACKn, BERRn              termination outputs, active-low
//   MEM_*                      memory-side request port
//   STATE_DBG                  current FSM state
// ---------------------------------------------------------------------------
module wf68k30l_bus_slave
  import wf68k30l_bus_slave_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter logic [31:0] MASK        = 32'h0000_0000,
  parameter int          WAIT_STATES = 4,
  parameter int          TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADR_IN,
  input  logic [2:0]  FC_IN,
  input  logic [1:0]  SIZE,
  input  logic        RWn,
  input  logic        ASn,
  input  logic        DSn,
  input  logic [31:0] DATA_FROM_CPU,
  output logic [31:0] DATA_TO_CPU,
  output logic        DATA_EN,
  output logic [1:0]  DSACKn,
  output logic        BERRn,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [29:0] MEM_ADDR,
  output logic [3:0]  MEM_BE,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  input  logic        MEM_ERR,
  output state_t      STATE_DBG
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15 || TIMEOUT < 1 || TIMEOUT > 1023)
  begin : g_param_check
    $error("wf68k30l_bus_slave: WAIT_STATES or TIMEOUT out of range");
  end

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [3:0] be_calc;
  logic       sel;
  logic       wd_hit;

  wf68k30l_bus_slave_be u_be (
    .SIZE   (SIZE),
    .ADR_LO (ADR_IN[1:0]),
    .BE     (be_calc)
  );

  assign sel = !ASn && !DSn && (FC_IN != FC_CPU_SPACE) &&
               ((ADR_IN & MASK) == BASE);

`ifdef WF68K30L_BUS_SLAVE_WATCHDOG_EN
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);
  logic [9:0] wd_cnt;
  // wd_cnt is 0 during the first MEM_REQ cycle, so WD_LAST is reached at the
  // end of the TIMEOUT-th cycle with MEM_REQ high.
  assign wd_hit = MEM_REQ && (wd_cnt == WD_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wd_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wd_cnt <= '0;
    end else if (MEM_REQ) begin
      wd_cnt <= wd_cnt + 10'd1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  assign STATE_DBG = state;

  // Memory handshake: MEM_REQ is a level that, once raised, stays high with
  // MEM_ADDR/MEM_WE/MEM_BE/MEM_WDATA stable until the cycle in which MEM_ACK
  // is sampled high (or the watchdog fires). MEM_ACK is a single-cycle
  // pulse; MEM_ERR is only meaningful in that same cycle. MEM_ACK seen while
  // no request is outstanding is ignored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      MEM_REQ     <= 1'b0;
      MEM_WE      <= 1'b0;
      MEM_ADDR    <= '0;
      MEM_BE      <= '0;
      MEM_WDATA   <= '0;
      DATA_TO_CPU <= '0;
      DATA_EN     <= 1'b0;
      DSACKn      <= 2'b11;
      BERRn       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel) begin
            state     <= ST_REQ;
            MEM_REQ   <= 1'b1;
            MEM_WE    <= ~RWn;
            MEM_ADDR  <= ADR_IN[31:2];
            MEM_BE    <= be_calc;
            MEM_WDATA <= DATA_FROM_CPU;
          end
        end

        ST_REQ: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            if (ASn) begin
              // CPU gave up in the same cycle the memory finished.
              state <= ST_IDLE;
            end else if (MEM_ERR) begin
              state <= ST_BERR;
              BERRn <= 1'b0;
            end else begin
              DATA_TO_CPU <= MEM_RDATA;
              if (WAIT_STATES != 0) begin
                state    <= ST_WAIT;
                wait_cnt <= '0;
              end else begin
                state   <= ST_TERM;
                DSACKn  <= 2'b00;
                DATA_EN <= ~MEM_WE;
              end
            end
          end else if (ASn) begin
            state <= ST_DRAIN;
          end else if (wd_hit) begin
            MEM_REQ <= 1'b0;
            state   <= ST_BERR;
            BERRn   <= 1'b0;
          end
        end

        ST_WAIT: begin
          if (ASn) begin
            // Memory already answered, so DRAIN exits on its next cycle.
            state <= ST_DRAIN;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ST_TERM;
            DSACKn  <= 2'b00;
            DATA_EN <= ~MEM_WE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        ST_TERM: begin
          if (ASn) begin
            state   <= ST_IDLE;
            DSACKn  <= 2'b11;
            DATA_EN <= 1'b0;
          end
        end

        ST_BERR: begin
          if (ASn) begin
            state <= ST_IDLE;
            BERRn <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (MEM_ACK || !MEM_REQ || wd_hit) begin
            state   <= ST_IDLE;
            MEM_REQ <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          MEM_REQ <= 1'b0;
          DSACKn  <= 2'b11;
          BERRn   <= 1'b1;
          DATA_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wf68k30l_bus_slave.sv
// ---------------------------------------------------------------------------
// tb_wf68k30l_bus_slave
// Two slaves share one CPU bus and one memory response path:
//   u_dut0 : default decode (answers everything), WAIT_STATES=0
//   u_dut3 : BASE=0x1000_0000 MASK=0xF000_0000, WAIT_STATES=3, TIMEOUT=16
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_wf68k30l_bus_slave;
  import wf68k30l_bus_slave_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADR_IN;
  logic [2:0]  FC_IN;
  logic [1:0]  SIZE;
  logic        RWn, ASn, DSn;
  logic [31:0] DATA_FROM_CPU;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK, MEM_ERR;

  logic [31:0] data_0, data_3;
  logic        den_0, den_3;
  logic [1:0]  dsack_0, dsack_3;
  logic        berr_0, berr_3;
  logic        req_0, req_3;
  logic        we_0, we_3;
  logic [29:0] addr_0, addr_3;
  logic [3:0]  be_0, be_3;
  logic [31:0] wdata_0, wdata_3;
  state_t      st_0, st_3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wf68k30l_bus_slave #(.WAIT_STATES(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .ADR_IN(ADR_IN), .FC_IN(FC_IN), .SIZE(SIZE),
    .RWn(RWn), .ASn(ASn), .DSn(DSn), .DATA_FROM_CPU(DATA_FROM_CPU),
    .DATA_TO_CPU(data_0), .DATA_EN(den_0), .DSACKn(dsack_0), .BERRn(berr_0),
    .MEM_REQ(req_0), .MEM_WE(we_0), .MEM_ADDR(addr_0), .MEM_BE(be_0),
    .MEM_WDATA(wdata_0), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .MEM_ERR(MEM_ERR), .STATE_DBG(st_0)
  );

  wf68k30l_bus_slave #(
    .BASE(32'h1000_0000), .MASK(32'hF000_0000), .WAIT_STATES(3), .TIMEOUT(16)
  ) u_dut3 (
    .CLK(CLK), .RESET(RESET), .ADR_IN(ADR_IN), .FC_IN(FC_IN), .SIZE(SIZE),
    .RWn(RWn), .ASn(ASn), .DSn(DSn), .DATA_FROM_CPU(DATA_FROM_CPU),
    .DATA_TO_CPU(data_3), .DATA_EN(den_3), .DSACKn(dsack_3), .BERRn(berr_3),
    .MEM_REQ(req_3), .MEM_WE(we_3), .MEM_ADDR(addr_3), .MEM_BE(be_3),
    .MEM_WDATA(wdata_3), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .MEM_ERR(MEM_ERR), .STATE_DBG(st_3)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a cycle and let the slaves sample it.
  task automatic start(input logic [31:0] adr, input logic [2:0] fc,
                       input logic [1:0] sz, input logic rw,
                       input logic [31:0] wd);
    ADR_IN = adr; FC_IN = fc; SIZE = sz; RWn = rw; DATA_FROM_CPU = wd;
    ASn = 1'b0; DSn = 1'b0;
    step();
  endtask

  task automatic ack(input logic [31:0] rd, input logic err);
    MEM_ACK = 1'b1; MEM_RDATA = rd; MEM_ERR = err;
    step();
    MEM_ACK = 1'b0; MEM_ERR = 1'b0; MEM_RDATA = 32'h0;
  endtask

  task automatic release_as();
    ASn = 1'b1; DSn = 1'b1;
    step();
  endtask

  initial begin
    RESET = 1'b1; ADR_IN = '0; FC_IN = 3'b001; SIZE = 2'b00; RWn = 1'b1;
    ASn = 1'b1; DSn = 1'b1; DATA_FROM_CPU = '0; MEM_RDATA = '0;
    MEM_ACK = 1'b0; MEM_ERR = 1'b0;
    step(); step();

    // Reset state
    check("rst_state", 32'(st_0), 32'(ST_IDLE));
    check("rst_req",   32'(req_0), 32'd0);
    check("rst_dsack", 32'(dsack_0), 32'h3);
    check("rst_berr",  32'(berr_0), 32'd1);
    check("rst_den",   32'(den_0), 32'd0);
    check("rst_be",    32'(be_0), 32'd0);
    check("rst_addr",  32'(addr_0), 32'd0);
    check("rst_data",  data_0, 32'd0);
    RESET = 1'b0;
    step();

    // Longword read at 0x100, ack two cycles into the request
    start(32'h0000_0100, 3'b001, 2'b00, 1'b1, 32'h0);
    check("lr_req",   32'(req_0), 32'd1);
    check("lr_be",    32'(be_0), 32'hF);
    check("lr_addr",  32'(addr_0), 32'h40);
    check("lr_we",    32'(we_0), 32'd0);
    check("lr_nosel", 32'(req_3), 32'd0);
    step();
    check("lr_hold", 32'(req_0), 32'd1);
    ack(32'hDEAD_BEEF, 1'b0);
    check("lr_dsack", 32'(dsack_0), 32'h0);
    check("lr_data",  data_0, 32'hDEAD_BEEF);
    check("lr_den",   32'(den_0), 32'd1);
    check("lr_reqlo", 32'(req_0), 32'd0);
    step();
    check("lr_dsack2", 32'(dsack_0), 32'h0);
    check("lr_den2",   32'(den_0), 32'd1);
    check("lr_ign3",   32'(dsack_3), 32'h3);
    check("lr_ign3st", 32'(st_3), 32'(ST_IDLE));
    release_as();
    check("lr_end_dsack", 32'(dsack_0), 32'h3);
    check("lr_end_den",   32'(den_0), 32'd0);
    check("lr_end_st",    32'(st_0), 32'(ST_IDLE));

    // Byte write at 0x103
    start(32'h0000_0103, 3'b001, 2'b01, 1'b0, 32'hAABB_CCDD);
    check("bw_be",    32'(be_0), 32'h1);
    check("bw_we",    32'(we_0), 32'd1);
    check("bw_wdata", wdata_0, 32'hAABB_CCDD);
    step(); step();
    check("bw_hold_be", 32'(be_0), 32'h1);
    check("bw_hold_wd", wdata_0, 32'hAABB_CCDD);
    ack(32'h0, 1'b0);
    check("bw_dsack", 32'(dsack_0), 32'h0);
    check("bw_den",   32'(den_0), 32'd0);
    release_as();

    // Word at 0x101 and 3-byte at 0x102
    start(32'h0000_0101, 3'b001, 2'b10, 1'b1, 32'h0);
    check("ww_be", 32'(be_0), 32'h6);
    ack(32'h1111_2222, 1'b0);
    release_as();
    start(32'h0000_0102, 3'b001, 2'b11, 1'b0, 32'h0);
    check("tb_be", 32'(be_0), 32'h3);
    ack(32'h0, 1'b0);
    release_as();

    // Three wait states on u_dut3 (u_dut0 also answers, with none)
    start(32'h1000_0010, 3'b101, 2'b00, 1'b1, 32'h0);
    check("ws_req",  32'(req_3), 32'd1);
    check("ws_addr", 32'(addr_3), 32'h0400_0004);
    ack(32'h1234_5678, 1'b0);
    check("ws_d0_dsack", 32'(dsack_0), 32'h0);
    check("ws_c1", 32'(dsack_3), 32'h3);
    step();
    check("ws_c2", 32'(dsack_3), 32'h3);
    step();
    check("ws_c3", 32'(dsack_3), 32'h3);
    step();
    check("ws_c4",   32'(dsack_3), 32'h0);
    check("ws_data", data_3, 32'h1234_5678);
    check("ws_den",  32'(den_3), 32'd1);
    release_as();
    check("ws_end", 32'(dsack_3), 32'h3);

    // Memory error -> bus error
    start(32'h0000_0200, 3'b001, 2'b00, 1'b1, 32'h0);
    ack(32'h0, 1'b1);
    check("be_berr",  32'(berr_0), 32'd0);
    check("be_dsack", 32'(dsack_0), 32'h3);
    step();
    check("be_hold", 32'(berr_0), 32'd0);
    release_as();
    check("be_end", 32'(berr_0), 32'd1);

    // CPU-space cycle is ignored
    start(32'h0000_0300, 3'b111, 2'b00, 1'b1, 32'h0);
    check("cpu_req", 32'(req_0), 32'd0);
    step();
    check("cpu_dsack", 32'(dsack_0), 32'h3);
    check("cpu_berr",  32'(berr_0), 32'd1);
    release_as();

    // Abort while in REQ -> DRAIN, request held until ack
    start(32'h0000_0400, 3'b001, 2'b00, 1'b1, 32'h0);
    release_as();
    check("ab_state", 32'(st_0), 32'(ST_DRAIN));
    check("ab_req",   32'(req_0), 32'd1);
    step();
    check("ab_req2",  32'(req_0), 32'd1);
    check("ab_dsack", 32'(dsack_0), 32'h3);
    ack(32'h5555_5555, 1'b0);
    check("ab_idle",  32'(st_0), 32'(ST_IDLE));
    check("ab_reqlo", 32'(req_0), 32'd0);
    check("ab_den",   32'(den_0), 32'd0);

    // Reset in the middle of a cycle
    start(32'h0000_0500, 3'b001, 2'b01, 1'b0, 32'h9999_0000);
    RESET = 1'b1; ASn = 1'b1; DSn = 1'b1;
    #2;
    check("mr_req",  32'(req_0), 32'd0);
    check("mr_be",   32'(be_0), 32'd0);
    check("mr_wd",   wdata_0, 32'd0);
    check("mr_st",   32'(st_0), 32'(ST_IDLE));
    step();
    RESET = 1'b0;
    step();

    // Request that memory never answers, targeting u_dut3
    start(32'h1000_0000, 3'b001, 2'b00, 1'b1, 32'h0);
`ifdef WF68K30L_BUS_SLAVE_WATCHDOG_EN
    for (int i = 0; i < 15; i++) step();
    check("wd_before_berr", 32'(berr_3), 32'd1);
    check("wd_before_req",  32'(req_3), 32'd1);
    step();
    check("wd_berr", 32'(berr_3), 32'd0);
    check("wd_req",  32'(req_3), 32'd0);
    release_as();
    check("wd_end", 32'(berr_3), 32'd1);
`else
    for (int i = 0; i < 20; i++) step();
    check("nowd_req",  32'(req_3), 32'd1);
    check("nowd_berr", 32'(berr_3), 32'd1);
    release_as();
`endif
    ack(32'h0, 1'b0);
    check("fin_st0", 32'(st_0), 32'(ST_IDLE));
    check("fin_st3", 32'(st_3), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
